// File: rtl/pico_clk_div_lock.sv
// Integer clock divider with programmable duty/phase and a sticky lock flag after LOCK_CYCLES reference edges.
// Optional output gate input when PICO_CLK_GATE_EN is defined.
module pico_clk_div_lock #(
    parameter int ODIV0       = 2,
    parameter int DUTY0       = 1,
    parameter int PHASE0      = 0,
    parameter int LOCK_CYCLES = 64
) (
    input  logic clkin1,
    input  logic rst_n,
`ifdef PICO_CLK_GATE_EN
    input  logic clkout0_gate,
`endif
    output logic clkout0,
    output logic pll_lock
);

    localparam int DW = (ODIV0 > 1) ? $clog2(ODIV0) : 1;
    localparam int LW = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;

    localparam logic [DW-1:0] DUTY_W    = DW'(DUTY0);
    localparam logic [DW-1:0] PHASE_W   = DW'(PHASE0);
    localparam logic [DW-1:0] DIV_LAST  = DW'(ODIV0 - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    generate
        if (ODIV0 < 2) begin : g_bad_odiv
            $error("pico_clk_div_lock: ODIV0 must be >= 2");
        end
        if (DUTY0 < 1 || DUTY0 > ODIV0 - 1) begin : g_bad_duty
            $error("pico_clk_div_lock: DUTY0 must be in 1..ODIV0-1");
        end
        if (PHASE0 < 0 || PHASE0 > ODIV0 - 1) begin : g_bad_phase
            $error("pico_clk_div_lock: PHASE0 must be in 0..ODIV0-1");
        end
        if (LOCK_CYCLES < 1) begin : g_bad_lock
            $error("pico_clk_div_lock: LOCK_CYCLES must be >= 1");
        end
    endgenerate

    logic          gate_w;
`ifdef PICO_CLK_GATE_EN
    assign gate_w = clkout0_gate;
`else
    assign gate_w = 1'b0;
`endif

    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_q, lock_d;
    logic [DW-1:0] div_q, div_d;
    logic          clk_q, clk_d;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        div_d      = div_q;
        // Counter freezes once locked, so lock can only rise once per reset.
        if (!lock_q) begin
            lock_cnt_d = lock_cnt_q + LW'(1);
            if (lock_cnt_q == LOCK_LAST) begin
                lock_d = 1'b1;
            end
        end
        if (lock_q) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end
        // Gating only masks the output; the divider keeps its phase.
        clk_d = lock_q & (div_q < DUTY_W) & ~gate_w;
    end

    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
            div_q      <= PHASE_W;
            clk_q      <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
            div_q      <= div_d;
            clk_q      <= clk_d;
        end
    end

    assign clkout0  = clk_q;
    assign pll_lock = lock_q;

endmodule

// File: tb/tb_pico_clk_div_lock.sv
// Bench for pico_clk_div_lock: three divider configurations sharing one reference clock and reset.
module tb_pico_clk_div_lock;

    localparam int L = 64;
`ifdef PICO_CLK_GATE_EN
    localparam bit GATE_ON = 1'b1;
`else
    localparam bit GATE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic gate = 1'b0;
    logic clk_a, clk_b, clk_c;
    logic lock_a, lock_b, lock_c;

    always #10 clk = ~clk;

    pico_clk_div_lock #(.ODIV0(2), .DUTY0(1), .PHASE0(0), .LOCK_CYCLES(L)) u_a (
        .clkin1(clk), .rst_n(rst_n),
`ifdef PICO_CLK_GATE_EN
        .clkout0_gate(gate),
`endif
        .clkout0(clk_a), .pll_lock(lock_a));

    pico_clk_div_lock #(.ODIV0(5), .DUTY0(2), .PHASE0(0), .LOCK_CYCLES(L)) u_b (
        .clkin1(clk), .rst_n(rst_n),
`ifdef PICO_CLK_GATE_EN
        .clkout0_gate(gate),
`endif
        .clkout0(clk_b), .pll_lock(lock_b));

    pico_clk_div_lock #(.ODIV0(4), .DUTY0(2), .PHASE0(2), .LOCK_CYCLES(L)) u_c (
        .clkin1(clk), .rst_n(rst_n),
`ifdef PICO_CLK_GATE_EN
        .clkout0_gate(gate),
`endif
        .clkout0(clk_c), .pll_lock(lock_c));

    int total = 0;
    int bad = 0;
    int n = 0;           // rising edges since reset release
    bit g_last = 1'b0;   // gate value seen at the most recent edge
    int rises = 0;
    int locks_expected = 0;

    always @(posedge lock_a) rises++;

    typedef struct {
        int   edge_n;
        logic lock;
        logic a;
        logic b;
        logic c;
    } vec_t;

    function automatic logic exp_clk(int odiv, int duty, int phase, int edges, bit gated);
        if (edges <= L || gated) return 1'b0;
        return ((phase + edges - L - 1) % odiv) < duty;
    endfunction

    task automatic chk(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%b want=%b", name, n, act, exp);
        end
    endtask

    task automatic check_model();
        logic lk;
        lk = (n >= L);
        chk("lock_a", lock_a, lk);
        chk("lock_b", lock_b, lk);
        chk("lock_c", lock_c, lk);
        chk("clk_a", clk_a, exp_clk(2, 1, 0, n, g_last));
        chk("clk_b", clk_b, exp_clk(5, 2, 0, n, g_last));
        chk("clk_c", clk_c, exp_clk(4, 2, 2, n, g_last));
    endtask

    // Inputs are changed only at negedge; outputs are sampled at negedge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            n++;
            g_last = gate;
            if (n == L) locks_expected++;
        end else begin
            n = 0;
            g_last = 1'b0;
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic pulse_reset(int hold);
        rst_n = 1'b0;
        #1;
        chk("rst_async_lock", lock_a, 1'b0);
        chk("rst_async_clk_a", clk_a, 1'b0);
        chk("rst_async_clk_b", clk_b, 1'b0);
        chk("rst_async_clk_c", clk_c, 1'b0);
        @(negedge clk);
        repeat (hold) cycle();
        rst_n = 1'b1;
        n = 0;
        g_last = 1'b0;
    endtask

    initial begin
        vec_t tbl[10];
        int   r0;

        tbl[0] = '{0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{63, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{64, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{65, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{66, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{67, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{68, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{69, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{70, 1'b1, 1'b0, 1'b1, 1'b0};

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            while (n < tbl[i].edge_n) cycle();
            chk("tbl_lock", lock_a, tbl[i].lock);
            chk("tbl_clk_a", clk_a, tbl[i].a);
            chk("tbl_clk_b", clk_b, tbl[i].b);
            chk("tbl_clk_c", clk_c, tbl[i].c);
        end

        // Long stable run: lock must never drop or pulse again.
        r0 = rises;
        repeat (20000) cycle();
        chk("single_lock_rise", (rises == r0) ? 1'b1 : 1'b0, 1'b1);

`ifdef PICO_CLK_GATE_EN
        gate = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("gate_clk_a_low", clk_a, 1'b0);
            chk("gate_lock_held", lock_a, 1'b1);
        end
        gate = 1'b0;
        repeat (20) cycle();
`endif

        // Randomized segments with mid-run resets and random gating.
        for (int s = 0; s < 6; s++) begin
            pulse_reset($urandom_range(0, 3));
            chk("release_lock", lock_a, 1'b0);
            for (int k = 0; k < $urandom_range(300, 3000); k++) begin
                if (GATE_ON) gate = ($urandom_range(0, 15) == 0);
                cycle();
            end
            gate = 1'b0;
        end
        repeat (5) cycle();

        chk("lock_rise_count", (rises == locks_expected) ? 1'b1 : 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
